bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double dabble) method.
- Sits directly upstream of the 4-digit multiplexed 7-segment driver and produces its 16-bit packed-BCD `data` word. The driver then shows decimal values instead of hex.
- One iteration per clock; start/ready/valid handshake.
- The converted result is held stable between updates so the display never shows intermediate values.

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 tb/tb_bin2bcd_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/ready/valid handshake bundle between a binary source and bin2bcd_seq.
// Signals: start, bin (source to converter); ready, valid, bcd, overflow (converter to source).
// With BIN2BCD_LZB_EN defined the bundle also carries blank (leading-zero mask, converter to source).
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0]     blank;
  modport master (output start, bin, input ready, valid, bcd, overflow, blank);
  modport slave  (input start, bin, output ready, valid, bcd, overflow, blank);
`else
  modport master (output start, bin, input ready, valid, bcd, overflow);
  modport slave  (input start, bin, output ready, valid, bcd, overflow);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary-to-BCD converter, one iteration per clock.
// Ports: clk, rst_n (async active-low), bus (bin2bcd_seq_if.slave: start/bin in, ready/valid/bcd/overflow out).
// Optional macro BIN2BCD_LZB_EN adds the registered leading-zero blank mask on bus.blank.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(10**DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state_q;
  logic [BIN_W-1:0]      shift_q;
  logic [4*DIGITS-1:0]   scratch_q, adj_d, bcd_q;
  logic [CW-1:0]         count_q;
  logic                  ovf_q, ready_q, valid_q, overflow_q;
  // add-3 correction applied to every scratch digit before the shift; digits stay 4-bit with no carry
  always_comb begin
    adj_d = scratch_q;
    for (int k = 0; k < DIGITS; k++)
      adj_d[4*k +: 4] = scratch_q[4*k +: 4] >= 4'd5 ? scratch_q[4*k +: 4] + 4'd3 : scratch_q[4*k +: 4];
  end
`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  // digit k blanks when it and every more-significant digit is zero; digit 0 always shows
  always_comb begin
    blank_d = '0;
    for (int k = 1; k < DIGITS; k++)
      blank_d[k] = !ovf_q && ((scratch_q >> (4*k)) == '0);
  end
  assign bus.blank = blank_q;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
`ifdef BIN2BCD_LZB_EN
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            count_q   <= CW'(BIN_W);
            ovf_q     <= bus.bin > MAX_V;
            ready_q   <= 1'b0;
            state_q   <= SHIFT;
          end
        SHIFT: begin
          {scratch_q, shift_q} <= {adj_d, shift_q} << 1;
          count_q <= count_q - 1'b1;
          if (count_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          bcd_q      <= ovf_q ? {DIGITS{4'h9}} : scratch_q;
          overflow_q <= ovf_q;
          valid_q    <= 1'b1;
          ready_q    <= 1'b1;
`ifdef BIN2BCD_LZB_EN
          blank_q    <= blank_d;
`endif
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.ready    = ready_q;
  assign bus.valid    = valid_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed scoreboard bench for bin2bcd_seq (decimal model, latency and handshake checks).
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   a;
  logic prev_v = 1'b0;
  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
    int          acc;
  } exp_t;
  exp_t q[$];
  bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();
  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    int   d;
    e.ovf   = v > 9999;
    e.bcd   = '0;
    e.blank = '0;
    e.acc   = acc;
    for (int k = 0; k < 4; k++) begin
      d = e.ovf ? 9 : (v / (10**k)) % 10;
      e.bcd[4*k +: 4] = d[3:0];
    end
    for (int k = 1; k < 4; k++) e.blank[k] = !e.ovf && (v < 10**k);
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      if (prev_v) chk("valid_one_cycle", 32'(bus.valid), 32'd0);
      if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.acc), 32'd15);
        chk("ready_at_valid", 32'(bus.ready), 32'd1);
`ifdef BIN2BCD_LZB_EN
        chk("blank", 32'(bus.blank), 32'(e.blank));
`endif
      end
    end
    prev_v <= rst_n && bus.valid;
  end
  task automatic conv(input int v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'(v);
    @(negedge clk);
    bus.start = 1'b0;
    q.push_back(model(v, cyc));
  endtask
  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_pending", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
`ifdef BIN2BCD_LZB_EN
    chk("rst_blank", 32'(bus.blank), 32'he);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    conv(0);     wait_idle();
    conv(1234);  wait_idle();
    conv(9999);  wait_idle();
    conv(10);    wait_idle();
    conv(10000); wait_idle();
    conv(5);     wait_idle();
    conv(1000);  wait_idle();
    conv(12000); wait_idle();
    conv(42);
    a = cyc;
    chk("busy_ready", 32'(bus.ready), 32'd0);
    while (cyc != a + 3) @(negedge clk);
    bus.start = 1'b1; bus.bin = 14'd777;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc != a + 10) @(negedge clk);
    bus.start = 1'b1; bus.bin = 14'd777;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc != a + 15) @(negedge clk);
    bus.start = 1'b1; bus.bin = 14'd777;
    q.push_back(model(777, a + 16));
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    conv(4321);
    a = cyc;
    void'(q.pop_back());
    while (cyc != a + 7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bus.bcd), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_bcd_held", 32'(bus.bcd), 32'd0);
    conv(4321);  wait_idle();
    repeat (4) begin
      conv(int'($urandom_range(0, 16383)));
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
